// File: rtl/interleaver_addr_ctrl.sv
// QPP interleaver address generator: issues pi(i) = (F1*i + F2*i^2) mod K for i = 0..K-1
// using incremental first/second differences, with a valid/ready output handshake.
module interleaver_addr_ctrl #(
    parameter int unsigned F1 = 3,
    parameter int unsigned F2 = 10
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        id_enable,
    input  logic [5:0]  link_id,
    input  logic        addr_ready,
    output logic        enable,
    output logic [12:0] data,
    output logic        last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    // Handshake: an address (data/last) is transferred on a rising clk edge where
    // enable && addr_ready; while enable is high and addr_ready low, data/last hold.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [12:0] G_INIT    = 13'(F1 + F2);
    localparam logic [12:0] STEP_INIT = 13'(2 * F2);

    state_t      state_q, state_d;
    logic [12:0] k_q, k_d;
    logic [12:0] i_q, i_d;
    logic [12:0] pi_q, pi_d;
    logic [12:0] g_q, g_d;
    logic [12:0] step_q, step_d;
    logic        enable_q, enable_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        accept;

    // Both operands are already reduced below m, so one subtraction suffices.
    function automatic logic [12:0] add_mod(input logic [12:0] a, input logic [12:0] b,
                                            input logic [12:0] m);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[12:0];
    endfunction

    assign accept = enable_q & addr_ready;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        i_d      = i_q;
        pi_d     = pi_q;
        g_d      = g_q;
        step_d   = step_q;
        enable_d = enable_q;
        last_d   = last_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_enable) begin
                    k_d     = {1'b0, link_id, 6'd0} + 13'd64;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                i_d      = 13'd0;
                pi_d     = 13'd0;
                g_d      = add_mod(G_INIT, 13'd0, k_q);
                step_d   = add_mod(STEP_INIT, 13'd0, k_q);
                enable_d = 1'b1;
                last_d   = 1'b0;
                state_d  = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (last_q) begin
                        enable_d = 1'b0;
                        last_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        pi_d   = add_mod(pi_q, g_q, k_q);
                        g_d    = add_mod(g_q, step_q, k_q);
                        i_d    = i_q + 13'd1;
                        // The next index is K-1 exactly when the current one is K-2.
                        last_d = (i_q + 13'd2 == k_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            k_q      <= 13'd0;
            i_q      <= 13'd0;
            pi_q     <= 13'd0;
            g_q      <= 13'd0;
            step_q   <= 13'd0;
            enable_q <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            i_q      <= i_d;
            pi_q     <= pi_d;
            g_q      <= g_d;
            step_q   <= step_d;
            enable_q <= enable_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign enable    = enable_q;
    assign data      = pi_q;
    assign last      = last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_interleaver_addr_ctrl.sv
// Bench for interleaver_addr_ctrl: table of frames plus reset-abort sequence, each frame
// scoreboarded against pi(i) = (F1*i + F2*i^2) mod K computed directly.
module tb_interleaver_addr_ctrl;

    localparam int F1 = 3;
    localparam int F2 = 10;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        id_enable;
    logic [5:0]  link_id;
    logic        addr_ready;
    logic        enable;
    logic [12:0] data;
    logic        last;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    logic [12:0] exp_q[$];

    typedef struct {
        logic [5:0] link_id;
        int         ready_pct;
        bit         inject;
        int         exp_k;
        int         exp_d1;
        int         exp_d2;
        int         exp_d3;
    } vec_t;

    vec_t vecs[6];

    interleaver_addr_ctrl #(.F1(F1), .F2(F2)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .id_enable  (id_enable),
        .link_id    (link_id),
        .addr_ready (addr_ready),
        .enable     (enable),
        .data       (data),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic int model_pi(input int i, input int k);
        longint v;
        v = longint'(F1) * i + longint'(F2) * i * i;
        return int'(v % k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int  k;
        int  accepted;
        int  cycles;
        bit  done_seen;
        bit  last_acc;
        bit  injected;
        k = v.exp_k;
        exp_q.delete();
        for (int i = 0; i < k; i++) exp_q.push_back(13'(model_pi(i, k)));

        id_enable  = 1'b1;
        link_id    = v.link_id;
        addr_ready = 1'b0;
        step();
        check("load_busy", 32'(busy), 1);
        check("load_enable", 32'(enable), 0);
        id_enable = 1'b0;
        link_id   = 6'($urandom_range(0, 63));
        step();
        check("first_enable", 32'(enable), 1);
        check("first_data", 32'(data), 0);

        accepted  = 0;
        cycles    = 0;
        done_seen = 1'b0;
        last_acc  = 1'b0;
        injected  = 1'b0;
        while (!done_seen && cycles < k * 20 + 50) begin
            if (last_acc) begin
                check("done_pulse", 32'(done), 1);
                check("done_enable", 32'(enable), 0);
                check("done_busy", 32'(busy), 1);
                done_seen  = 1'b1;
                addr_ready = 1'b0;
                id_enable  = 1'b1;
                link_id    = 6'h3F;
                step();
                check("idle_busy", 32'(busy), 0);
                check("idle_done", 32'(done), 0);
                check("idle_enable", 32'(enable), 0);
                id_enable = 1'b0;
                step();
                check("strobe_at_done_ignored", 32'(busy), 0);
            end else begin
                check("run_enable", 32'(enable), 1);
                check("run_done", 32'(done), 0);
                if (enable) begin
                    check("data", 32'(data), 32'(exp_q[0]));
                    check("last", 32'(last), 32'(exp_q.size() == 1));
                    if (accepted == 1) check("tbl_d1", 32'(data), 32'(v.exp_d1));
                    if (accepted == 2) check("tbl_d2", 32'(data), 32'(v.exp_d2));
                    if (accepted == 3) check("tbl_d3", 32'(data), 32'(v.exp_d3));
                end
                addr_ready = ($urandom_range(1, 100) <= v.ready_pct);
                if (v.inject && !injected && accepted == 5) begin
                    id_enable = 1'b1;
                    link_id   = 6'h3F;
                    injected  = 1'b1;
                end else begin
                    id_enable = 1'b0;
                end
                if (addr_ready && enable) begin
                    check("addr_range", 32'(data < 13'(k)), 1);
                    void'(exp_q.pop_front());
                    accepted++;
                    if (exp_q.size() == 0) last_acc = 1'b1;
                end
                step();
                cycles++;
            end
        end
        id_enable  = 1'b0;
        addr_ready = 1'b0;
        if (!done_seen) check("frame_timeout", 0, 1);
        check("frame_len", 32'(accepted), 32'(k));
    endtask

    task automatic reset_abort();
        id_enable  = 1'b1;
        link_id    = 6'h00;
        addr_ready = 1'b0;
        step();
        id_enable  = 1'b0;
        step();
        addr_ready = 1'b1;
        for (int c = 0; c < 10; c++) step();
        check("abort_pre_data", 32'(data), 32'(model_pi(10, 64)));
        check("abort_pre_enable", 32'(enable), 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_enable", 32'(enable), 0);
        check("async_data", 32'(data), 0);
        check("async_last", 32'(last), 0);
        check("async_busy", 32'(busy), 0);
        check("async_done", 32'(done), 0);
        addr_ready = 1'b0;
        step();
        step();
        n_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_reset_done", 32'(done), 0);
            check("post_reset_busy", 32'(busy), 0);
            check("post_reset_enable", 32'(enable), 0);
        end
    endtask

    initial begin
        vecs[0] = '{6'h00, 100, 1'b0,   64, 13, 46, 35};
        vecs[1] = '{6'h00,  40, 1'b0,   64, 13, 46, 35};
        vecs[2] = '{6'h01,  70, 1'b1,  128, 13, 46, 99};
        vecs[3] = '{6'h14, 100, 1'b1, 1344, 13, 46, 99};
        vecs[4] = '{6'h3F, 100, 1'b0, 4096, 13, 46, 99};
        vecs[5] = '{6'h07,  50, 1'b1,  512, 13, 46, 99};

        n_rst      = 1'b0;
        id_enable  = 1'b0;
        link_id    = 6'h00;
        addr_ready = 1'b0;
        step();
        step();
        check("rst_enable", 32'(enable), 0);
        check("rst_data", 32'(data), 0);
        check("rst_last", 32'(last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        n_rst = 1'b1;
        step();
        check("idle_no_strobe", 32'(busy), 0);

        for (int n = 0; n < 6; n++) run_frame(vecs[n]);

        reset_abort();
        run_frame(vecs[0]);

        for (int n = 0; n < 3; n++) begin
            vec_t r;
            int   k;
            r.link_id   = 6'($urandom_range(0, 15));
            k           = (int'(r.link_id) + 1) * 64;
            r.ready_pct = $urandom_range(30, 100);
            r.inject    = 1'b1;
            r.exp_k     = k;
            r.exp_d1    = model_pi(1, k);
            r.exp_d2    = model_pi(2, k);
            r.exp_d3    = model_pi(3, k);
            run_frame(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
